// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : Multiplexed driver for NUM_DIGITS common-anode seven-segment
//            digits. An internal prescaler divides clk into digit slots; each
//            slot begins with an anode-off guard interval to suppress
//            ghosting. Provides per-digit decimal point, blink mask and forced
//            blank, plus an internal blink timebase counted in scan frames.
// Ports    : clk            system clock
//            rst            asynchronous reset, active-high
//            digits_i       nibble i = hex value of digit i (digit 0 rightmost)
//            dp_i           1 = decimal point lit on digit i
//            blink_mask_i   1 = digit i dark while blink_phase_o = 1
//            blank_i        1 = digit i forced dark (segments and dp)
//            seg_o          active-low segments, [7]=dp, [6:0]=g..a
//            an_o           active-low anodes, an_o[i] selects digit i
//            blink_phase_o  current blink half-period
//            frame_done_o   one-cycle pulse after the scan wraps to digit 0
// Options  : define SEG_LZB_EN to enable leading-zero blanking
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    blink_phase_o,
  output logic                    frame_done_o
);

  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_PRE_W = $clog2(REFRESH_DIV);
  localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
  localparam logic [c_PRE_W-1:0] c_GUARD    = c_PRE_W'(GUARD_CYCLES);
  localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);

  // Hex to active-low g..a pattern.
  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0:    r = 7'h40;
      4'h1:    r = 7'h79;
      4'h2:    r = 7'h24;
      4'h3:    r = 7'h30;
      4'h4:    r = 7'h19;
      4'h5:    r = 7'h12;
      4'h6:    r = 7'h02;
      4'h7:    r = 7'h78;
      4'h8:    r = 7'h00;
      4'h9:    r = 7'h10;
      4'hA:    r = 7'h08;
      4'hB:    r = 7'h03;
      4'hC:    r = 7'h46;
      4'hD:    r = 7'h21;
      4'hE:    r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  // started_q is clear only between reset release and the first edge, which
  // opens the digit-0 slot without advancing the index or pulsing frame_done.
  logic                  started_q, started_d;
  logic [c_PRE_W-1:0]    presc_q, presc_d;
  logic [c_IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic [c_FRM_W-1:0]    frm_q, frm_d;
  logic                  blink_q, blink_d;

  logic                  w_slot_start;
  logic                  w_an_on;
  logic [3:0]            w_nib;
  logic [7:0]            w_slot_seg;
  logic                  w_lead_blank;

  // Segment value for the digit that the next slot will show. Evaluated on
  // idx_d so the inputs are captured on the very edge that opens the slot.
  always_comb begin
    w_nib = digits_i[4*int'(idx_d) +: 4];
  end

`ifdef SEG_LZB_EN
  // Bit i set when nibble i and every more-significant nibble are zero.
  logic [NUM_DIGITS:0] w_zero_above;
  always_comb begin
    w_zero_above             = '0;
    w_zero_above[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above[i] = w_zero_above[i+1] && (digits_i[4*i +: 4] == 4'h0);
    end
  end
  assign w_lead_blank = (idx_d != '0) && w_zero_above[idx_d];
`else
  assign w_lead_blank = 1'b0;
`endif

  always_comb begin
    w_slot_seg = {~dp_i[idx_d], f_decode(w_nib)};
    if (blank_i[idx_d]) begin
      w_slot_seg = 8'hFF;
    end else if (blink_q && blink_mask_i[idx_d]) begin
      w_slot_seg = 8'hFF;
    end else if (w_lead_blank) begin
      // Suppressed digit may still show its own decimal point.
      w_slot_seg = {~dp_i[idx_d], 7'h7F};
    end
  end

  // Next-state logic for prescaler, scan index, outputs and blink timebase.
  always_comb begin
    started_d    = 1'b1;
    presc_d      = presc_q;
    idx_d        = idx_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    frm_d        = frm_q;
    blink_d      = blink_q;
    w_slot_start = 1'b0;

    if (!started_q) begin
      w_slot_start = 1'b1;
      presc_d      = '0;
    end else if (presc_q == c_PRE_LAST) begin
      w_slot_start = 1'b1;
      presc_d      = '0;
      idx_d        = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
      frame_done_d = (idx_q == c_LAST_IDX);
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (w_slot_start) begin
      seg_d = w_slot_seg;
    end

    // Blink state moves on the edge that samples the frame_done pulse; the
    // display only picks it up at the following slot start.
    if (frame_done_q) begin
      if (frm_q == c_FRM_LAST) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // Anode follows the prescaler value being loaded, so a zero guard lights
    // the anode together with the new segment pattern.
    w_an_on = (presc_d >= c_GUARD);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = !(w_an_on && (idx_d == c_IDX_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_q    <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
      frm_q        <= '0;
      blink_q      <= 1'b0;
    end else begin
      started_q    <= started_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      frm_q        <= frm_d;
      blink_q      <= blink_d;
    end
  end

  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign blink_phase_o = blink_q;
  assign frame_done_o  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seven_seg_scanner
// Purpose  : Scoreboard bench for seven_seg_scanner. A 4-digit instance
//            (REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_FRAMES=2) and a 1-digit
//            instance (REFRESH_DIV=2, GUARD_CYCLES=0, BLINK_FRAMES=2).
//            Expected per-slot values are queued by the stimulus and popped
//            by monitors when the DUT lights a digit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  localparam int BF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-digit DUT ----------------
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp, mask, blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        blink, fd;

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_i     (digits),
    .dp_i         (dp),
    .blink_mask_i (mask),
    .blank_i      (blank),
    .seg_o        (seg),
    .an_o         (an),
    .blink_phase_o(blink),
    .frame_done_o (fd)
  );

  // ---------------- 1-digit DUT ----------------
  logic       rst1;
  logic [3:0] digits1;
  logic       dp1, mask1, blank1;
  logic [7:0] seg1;
  logic       an1, blink1, fd1;

  seven_seg_scanner #(
    .NUM_DIGITS  (1),
    .REFRESH_DIV (2),
    .GUARD_CYCLES(0),
    .BLINK_FRAMES(BF)
  ) dut1 (
    .clk          (clk),
    .rst          (rst1),
    .digits_i     (digits1),
    .dp_i         (dp1),
    .blink_mask_i (mask1),
    .blank_i      (blank1),
    .seg_o        (seg1),
    .an_o         (an1),
    .blink_phase_o(blink1),
    .frame_done_o (fd1)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       blink;
  } exp_t;

  typedef struct packed {
    logic       an;
    logic [7:0] seg;
    logic       fd;
    logic       blink;
  } exp1_t;

  exp_t  q[$];
  exp1_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int i, input logic [15:0] d, input logic [3:0] p,
                                         input logic [3:0] m, input logic [3:0] b, input logic bl);
    logic [7:0] r;
    r    = dec(d[4*i +: 4]);
    r[7] = ~p[i];
`ifdef SEG_LZB_EN
    if (i > 0 && (d >> (4*i)) == 16'h0) r = p[i] ? 8'h7F : 8'hFF;
`endif
    if (bl && m[i]) r = 8'hFF;
    if (b[i])       r = 8'hFF;
    return r;
  endfunction

  // Frame_done pulses seen since the last reset (bench-side model state).
  int nf;
  always @(posedge clk or posedge rst) begin
    if (rst)     nf <= 0;
    else if (fd) nf <= nf + 1;
  end

  // Monitor for the 4-digit DUT: a digit is presented when an anode turns on
  // after the all-off guard cycle.
  logic [3:0] an_prev;
  int cyc = 0;
  int last_fd;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      an_prev = 4'hF;
      last_fd = -1;
    end else begin
      if (fd) begin
        if (last_fd >= 0) check("frame_period", cyc - last_fd, ND*RD);
        last_fd = cyc;
      end
      if (an != 4'hF && an_prev == 4'hF && q.size() > 0) begin
        e = q.pop_front();
        check("slot_an",    an,    e.an);
        check("slot_seg",   seg,   e.seg);
        check("slot_blink", blink, e.blink);
      end
      an_prev = an;
    end
  end

  // Monitor for the 1-digit DUT: one record per cycle after reset release.
  always @(negedge clk) begin
    exp1_t e;
    if (!rst1 && q1.size() > 0) begin
      e = q1.pop_front();
      check("d1_an",    an1,    e.an);
      check("d1_seg",   seg1,   e.seg);
      check("d1_fd",    fd1,    e.fd);
      check("d1_blink", blink1, e.blink);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_frame();
    bit got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (fd) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_wait: got no frame_done expected pulse within 64 cycles");
    end
  endtask

  // Called at the negedge of the frame_done cycle of frame n = nf+1.
  // Digit 0 of frame n was latched before pulse n updated the blink state.
  task automatic push_frame();
    exp_t e;
    int   n;
    logic bl_new, bl_old;
    n      = nf + 1;
    bl_new = ((n / 2) % 2) == 1;
    bl_old = (((n - 1) / 2) % 2) == 1;
    check("sb_drain", q.size(), 0);
    for (int i = 0; i < ND; i++) begin
      e.an    = ~(4'b0001 << i);
      e.seg   = exp_seg(i, digits, dp, mask, blank, (i == 0) ? bl_old : bl_new);
      e.blink = bl_new;
      q.push_back(e);
    end
  endtask

  task automatic run_frames(input int k);
    for (int j = 0; j < k; j++) begin
      wait_frame();
      push_frame();
    end
  endtask

  // ---------------- 1-digit DUT stimulus ----------------
  initial begin
    exp1_t e1;
    int    h;
    rst1    = 1'b0;
    digits1 = 4'h3;
    dp1     = 1'b0;
    mask1   = 1'b0;
    blank1  = 1'b0;
    #1 rst1 = 1'b1;
    repeat (3) @(negedge clk);
    // Record c describes the outputs after the c-th edge following release.
    for (int c = 1; c <= 16; c++) begin
      h        = (c >= 4) ? (c - 2) / 2 : 0;
      e1.an    = 1'b0;
      e1.seg   = 8'hB0;
      e1.fd    = (c >= 3) && (c % 2 == 1);
      e1.blink = ((h / 2) % 2) == 1;
      q1.push_back(e1);
    end
    #2 rst1 = 1'b0;
  end

  // ---------------- 4-digit DUT stimulus ----------------
  initial begin
    bit found;
    rst    = 1'b0;
    digits = 16'h12A9;
    dp     = 4'b0000;
    mask   = 4'b0000;
    blank  = 4'b0000;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seg",   seg,   8'hFF);
    check("rst_an",    an,    4'hF);
    check("rst_blink", blink, 1'b0);
    check("rst_fd",    fd,    1'b0);

    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("first_guard_an", an, 4'hF);
    check("first_fd",       fd, 1'b0);
    @(posedge clk); #1;
    check("first_slot_an",  an,  4'hE);
    check("first_slot_seg", seg, 8'h90);

    // Plain scan of 12A9.
    run_frames(2);

    // Priority: blank over blink over decode, dp on digit 0.
    wait_frame();
    digits = 16'h12A0;
    blank  = 4'b0001;
    mask   = 4'b0001;
    dp     = 4'b0001;
    run_frames(4);
    wait_frame();
    blank  = 4'b0000;
    run_frames(4);

    // Mid-slot change of digit 0: new value only shows on its next slot.
    wait_frame();
    digits = 16'h1235;
    dp     = 4'b0000;
    mask   = 4'b0000;
    run_frames(1);
    digits = 16'h1237;
    run_frames(1);

    // Leading zeros (suppressed only when the option is built in).
    wait_frame();
    digits = 16'h0040;
    run_frames(1);
    wait_frame();
    digits = 16'h0000;
    dp     = 4'b0100;
    run_frames(1);

    // Reset in the middle of the digit-2 slot.
    wait_frame();
    digits = 16'h12A9;
    dp     = 4'b0000;
    found  = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1'b1;
    end
    check("mid_rst_reach_digit2", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_seg",   seg,   8'hFF);
    check("mid_rst_an",    an,    4'hF);
    check("mid_rst_blink", blink, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_guard_an", an, 4'hF);
    @(posedge clk); #1;
    check("mid_rst_slot_an",  an,  4'hE);
    check("mid_rst_slot_seg", seg, 8'h90);
    run_frames(2);

    // Let the last queued slots drain.
    for (int k = 0; k < 40 && (q.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    check("final_drain",  q.size(),  0);
    check("final_drain1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
